if_id_queue: RTL and testbench
==============================

# if_id_queue

Decoupling buffer between the PC/instruction-memory fetch stage and the decode stage of the 16-bit WISC pipeline. A DEPTH-entry FIFO captures each fetched instruction with its PC and PC+2, and presents the oldest one to decode with a valid/ready handshake. It absorbs decode stalls without stalling fetch for up to DEPTH instructions. It also supports a pipeline flush and latches HALT detection so fetch stops cleanly.

## Interface
- DEPTH, 2, number of buffered entries (power of two, ≥2)
- INSTR_W, 16, instruction and PC width

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- if_valid  input  1  fetch stage presents an instruction
- if_instr  input  INSTR_W  fetched instruction
- if_pc  input  INSTR_W  address of if_instr
- if_ready  output  1  buffer accepts an enqueue this cycle
- id_valid  output  1  head entry valid for decode
- id_ready  input  1  decode consumes the head this cycle
- id_instr  output  INSTR_W  head instruction (NOP when empty)
- id_pc  output  INSTR_W  head PC
- id_pc_inc  output  INSTR_W  head PC + 2
- flush  input  1  discard all entries (branch or jump redirect)
- halt_seen  output  1  a HALT has been enqueued, and fetch is blocked
- count  output  $clog2(DEPTH+1)  current occupancy

## Operation
- Enqueue fires when if_valid && if_ready. Dequeue fires when id_valid && id_ready.
- if_ready = (count < DEPTH) && !halt_seen. It is combinational and does not depend on if_valid, id_ready, or flush.
  - When full, a same-cycle dequeue does not open a slot.
- id_valid = (count != 0).
- id_instr, id_pc, and id_pc_inc are muxed from the head entry.
  - When empty: id_instr = 16'h0800 (NOP), and id_pc = id_pc_inc = 16'h0000.
- id_pc_inc is computed at enqueue as if_pc + 2, modulo 2^16 (16'hFFFE gives 16'h0000), and stored per entry.
- Simultaneous enqueue and dequeue (not full, not empty): count is unchanged, and both pointers advance.
- Pointers wrap modulo DEPTH.
- HALT detection: an enqueued if_instr with bits [15:11] == 5'b00000 sets halt_seen at the next edge.
  - The HALT itself is buffered and delivered to decode normally.
  - halt_seen stays set until flush or rst.
- Flush is synchronous and has the highest priority among synchronous events. At the edge:
  - count and both pointers go to 0, and halt_seen is cleared.
  - Any enqueue or dequeue handshake in that cycle is discarded (it has no effect).
- rst is asynchronous and overrides everything. Entry storage need not be reset, but outputs must show the empty values.

## Timing
- Reset values: if_ready=1, id_valid=0, id_instr=16'h0800, id_pc=16'h0000, id_pc_inc=16'h0000, halt_seen=0, count=0.
- Enqueue-to-decode latency: 1 cycle. An instruction accepted at edge N is visible on id_* after edge N when it is at the head.
- Dequeue takes effect at the edge. The next entry, or NOP if now empty, is visible after that edge.
- if_ready drops in the cycle after the DEPTH-th outstanding enqueue. It rises the cycle after a dequeue from full.
- if_ready falls the cycle after the HALT enqueue edge.
- Flush at edge N: id_valid=0 after N, and if_ready=1 after N.
- rst asserted mid-operation: outputs go to reset values immediately, without waiting for clk.

## Structure
- Shared package wisc_pkg: NOP_INSTR = 16'h0800, HALT_OPC = 5'b00000, INSTR_W.
- One sub-module: if_id_fifo_ctrl, which holds the head/tail pointers, the occupancy counter, and the full/empty flags with flush priority.
- The top level holds the entry arrays {instr, pc, pc_inc}, HALT detection, and the output mux.

## Test plan
- Reset then idle, with if_valid=0 → id_valid=0, id_instr=16'h0800, if_ready=1, count=0.
- Enqueue 16'h1234@pc 16'h0000, then 16'h5678@pc 16'h0002, with id_ready=0 → count=2 and if_ready=0. Then id_ready=1 → head 16'h1234 with id_pc_inc=16'h0002, next cycle 16'h5678 with id_pc_inc=16'h0004.
- Continuous streaming (if_valid=1, id_ready=1, 10 instructions) → count stays at 1. Order is preserved, with no drops or duplicates.
- Enqueue at pc 16'hFFFE → id_pc_inc=16'h0000.
- Enqueue HALT 16'h0000 → halt_seen=1 and if_ready=0 next cycle, and HALT is still delivered to decode. Then flush → halt_seen=0, count=0, if_ready=1.
- Flush while full with a simultaneous if_valid → count=0 next cycle, and the flushed-cycle instruction never appears on id_*.
- Assert rst asynchronously mid-stream between clock edges → outputs return to reset values immediately.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared constants for the 16-bit WISC pipeline front end.
package wisc_pkg;
    localparam int          INSTR_W   = 16;
    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]  HALT_OPC  = 5'b00000;
    localparam logic [15:0] PC_STEP   = 16'd2;
endpackage

// File: rtl/if_id_fifo_ctrl.sv
// Pointer and occupancy control for the IF/ID queue; flush outranks enqueue/dequeue.
module if_id_fifo_ctrl #(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq,
    input  logic             deq,
    input  logic             flush,
    output logic [PTR_W-1:0] head,
    output logic [PTR_W-1:0] tail,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic enq_ok;
    logic deq_ok;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign enq_ok = enq && !full;
    assign deq_ok = deq && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_ok) tail <= tail + PTR_W'(1);
            if (deq_ok) head <= head + PTR_W'(1);
            case ({enq_ok, deq_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling FIFO: buffers fetched instr/pc/pc+2, presents the head to decode,
// and blocks fetch once a HALT has been accepted until the next flush.
module if_id_queue
    import wisc_pkg::*;
#(
    parameter  int DEPTH   = 2,
    parameter  int INSTR_W = wisc_pkg::INSTR_W,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_valid,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic [INSTR_W-1:0] if_pc,
    output logic               if_ready,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [INSTR_W-1:0] id_pc,
    output logic [INSTR_W-1:0] id_pc_inc,
    input  logic               flush,
    output logic               halt_seen,
    output logic [CNT_W-1:0]   count
);
    logic [INSTR_W-1:0] instr_mem  [DEPTH];
    logic [INSTR_W-1:0] pc_mem     [DEPTH];
    logic [INSTR_W-1:0] pc_inc_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             full;
    logic             empty;
    logic             enq;
    logic             deq;

    assign if_ready = !full && !halt_seen;
    assign id_valid = !empty;
    assign enq      = if_valid && if_ready;
    assign deq      = id_valid && id_ready;

    if_id_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .enq   (enq),
        .deq   (deq),
        .flush (flush),
        .head  (head),
        .tail  (tail),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // NOTE: entry storage is deliberately not reset; the output mux hides stale data while empty.
    always_ff @(posedge clk) begin
        if (enq && !flush) begin
            instr_mem[tail]  <= if_instr;
            pc_mem[tail]     <= if_pc;
            pc_inc_mem[tail] <= if_pc + INSTR_W'(PC_STEP);
        end
    end

    // Sticky until flush: the HALT itself still drains to decode normally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_seen <= 1'b0;
        end else if (flush) begin
            halt_seen <= 1'b0;
        end else if (enq && (if_instr[INSTR_W-1 -: 5] == HALT_OPC)) begin
            halt_seen <= 1'b1;
        end
    end

    // NOTE: every output gets a default first so this block can never infer a latch.
    always_comb begin
        id_instr  = INSTR_W'(NOP_INSTR);
        id_pc     = '0;
        id_pc_inc = '0;
        if (!empty) begin
            id_instr  = instr_mem[head];
            id_pc     = pc_mem[head];
            id_pc_inc = pc_inc_mem[head];
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_if_id_queue;
    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              if_valid;
    logic [15:0]       if_instr;
    logic [15:0]       if_pc;
    logic              if_ready;
    logic              id_valid;
    logic              id_ready;
    logic [15:0]       id_instr;
    logic [15:0]       id_pc;
    logic [15:0]       id_pc_inc;
    logic              flush;
    logic              halt_seen;
    logic [CNT_W-1:0]  count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: the buffered entries in order, plus the sticky halt flag.
    logic [15:0] mq_instr[$];
    logic [15:0] mq_pc[$];
    bit          m_halt;

    if_id_queue #(.DEPTH(DEPTH), .INSTR_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .if_ready  (if_ready),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_instr  (id_instr),
        .id_pc     (id_pc),
        .id_pc_inc (id_pc_inc),
        .flush     (flush),
        .halt_seen (halt_seen),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_instr();
        return (mq_instr.size() != 0) ? mq_instr[0] : 16'h0800;
    endfunction

    function automatic logic [15:0] exp_pc();
        return (mq_pc.size() != 0) ? mq_pc[0] : 16'h0000;
    endfunction

    function automatic logic [15:0] exp_pc_inc();
        return (mq_pc.size() != 0) ? mq_pc[0] + 16'd2 : 16'h0000;
    endfunction

    function automatic logic exp_ready();
        return (mq_instr.size() < DEPTH) && !m_halt;
    endfunction

    function automatic void model_clear();
        mq_instr.delete();
        mq_pc.delete();
        m_halt = 1'b0;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, land 1 time unit after it.
    task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] p,
                        input logic rdy, input logic fl);
        bit enq_f;
        bit deq_f;
        if_valid = v;
        if_instr = ins;
        if_pc    = p;
        id_ready = rdy;
        flush    = fl;
        enq_f = v && exp_ready();
        deq_f = rdy && (mq_instr.size() != 0);
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else begin
            if (deq_f) begin
                void'(mq_instr.pop_front());
                void'(mq_pc.pop_front());
            end
            if (enq_f) begin
                mq_instr.push_back(ins);
                mq_pc.push_back(p);
                if (ins[15:11] == 5'b00000) m_halt = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            tests_run += 7;
            if (if_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_if_ready: got %b expected 1", if_ready); end
            if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
            if (id_instr !== 16'h0800) begin tests_failed++; $display("FAIL reset_id_instr: got %h expected 0800", id_instr); end
            if (id_pc !== 16'h0000) begin tests_failed++; $display("FAIL reset_id_pc: got %h expected 0000", id_pc); end
            if (id_pc_inc !== 16'h0000) begin tests_failed++; $display("FAIL reset_id_pc_inc: got %h expected 0000", id_pc_inc); end
            if (halt_seen !== 1'b0) begin tests_failed++; $display("FAIL reset_halt_seen: got %b expected 0", halt_seen); end
            if (count !== CNT_W'(0)) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", count); end
            step(1'b0, 16'hFFFF, 16'h1111, 1'b0, 1'b0);
        end
    endtask

    task automatic test_fill_drain();
        step(1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 16'h5678, 16'h0002, 1'b0, 1'b0);
        tests_run += 5;
        if (count !== CNT_W'(2)) begin tests_failed++; $display("FAIL fill_count: got %0d expected 2", count); end
        if (if_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_if_ready: got %b expected 0", if_ready); end
        if (id_valid !== 1'b1) begin tests_failed++; $display("FAIL fill_id_valid: got %b expected 1", id_valid); end
        if (id_instr !== 16'h1234) begin tests_failed++; $display("FAIL fill_head_instr: got %h expected 1234", id_instr); end
        if (id_pc_inc !== 16'h0002) begin tests_failed++; $display("FAIL fill_head_pc_inc: got %h expected 0002", id_pc_inc); end
        // A dequeue from full must not let a same-cycle enqueue in.
        step(1'b1, 16'h9ABC, 16'h0004, 1'b1, 1'b0);
        tests_run += 4;
        if (id_instr !== 16'h5678) begin tests_failed++; $display("FAIL drain_second_instr: got %h expected 5678", id_instr); end
        if (id_pc_inc !== 16'h0004) begin tests_failed++; $display("FAIL drain_second_pc_inc: got %h expected 0004", id_pc_inc); end
        if (count !== CNT_W'(1)) begin tests_failed++; $display("FAIL drain_count: got %0d expected 1", count); end
        if (if_ready !== 1'b1) begin tests_failed++; $display("FAIL drain_if_ready: got %b expected 1", if_ready); end
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        tests_run += 2;
        if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_empty_valid: got %b expected 0", id_valid); end
        if (id_instr !== 16'h0800) begin tests_failed++; $display("FAIL drain_empty_nop: got %h expected 0800", id_instr); end
    endtask

    task automatic test_streaming();
        logic [15:0] sent[$];
        logic [15:0] got[$];
        logic [15:0] ins;
        for (int i = 0; i <= 10; i++) begin
            ins = 16'h8000 | (16'(i) * 16'h0111);
            if (id_valid) got.push_back(id_instr);
            if (i < 10) sent.push_back(ins);
            step(i < 10, ins, 16'(i * 2), 1'b1, 1'b0);
            tests_run++;
            if (count !== CNT_W'((i < 10) ? 1 : 0)) begin
                tests_failed++;
                $display("FAIL stream_count[%0d]: got %0d expected %0d", i, count, (i < 10) ? 1 : 0);
            end
        end
        tests_run++;
        if (got.size() != sent.size()) begin
            tests_failed++;
            $display("FAIL stream_length: got %0d expected %0d", got.size(), sent.size());
        end else begin
            for (int i = 0; i < sent.size(); i++) begin
                tests_run++;
                if (got[i] !== sent[i]) begin
                    tests_failed++;
                    $display("FAIL stream_order[%0d]: got %h expected %h", i, got[i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_pc_wrap();
        step(1'b1, 16'hA5A5, 16'hFFFE, 1'b0, 1'b0);
        tests_run += 2;
        if (id_pc !== 16'hFFFE) begin tests_failed++; $display("FAIL wrap_pc: got %h expected FFFE", id_pc); end
        if (id_pc_inc !== 16'h0000) begin tests_failed++; $display("FAIL wrap_pc_inc: got %h expected 0000", id_pc_inc); end
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    endtask

    task automatic test_halt_flush();
        step(1'b1, 16'h0000, 16'h0100, 1'b0, 1'b0);
        tests_run += 4;
        if (halt_seen !== 1'b1) begin tests_failed++; $display("FAIL halt_set: got %b expected 1", halt_seen); end
        if (if_ready !== 1'b0) begin tests_failed++; $display("FAIL halt_if_ready: got %b expected 0", if_ready); end
        if (id_instr !== 16'h0000) begin tests_failed++; $display("FAIL halt_delivered: got %h expected 0000", id_instr); end
        if (id_pc_inc !== 16'h0102) begin tests_failed++; $display("FAIL halt_pc_inc: got %h expected 0102", id_pc_inc); end
        step(1'b1, 16'h9999, 16'h0102, 1'b1, 1'b0);
        tests_run += 3;
        if (count !== CNT_W'(0)) begin tests_failed++; $display("FAIL halt_blocks_fetch: got %0d expected 0", count); end
        if (halt_seen !== 1'b1) begin tests_failed++; $display("FAIL halt_sticky: got %b expected 1", halt_seen); end
        if (if_ready !== 1'b0) begin tests_failed++; $display("FAIL halt_ready_held: got %b expected 0", if_ready); end
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        tests_run += 3;
        if (halt_seen !== 1'b0) begin tests_failed++; $display("FAIL flush_clears_halt: got %b expected 0", halt_seen); end
        if (count !== CNT_W'(0)) begin tests_failed++; $display("FAIL flush_halt_count: got %0d expected 0", count); end
        if (if_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_if_ready: got %b expected 1", if_ready); end
    endtask

    task automatic test_flush_full();
        step(1'b1, 16'h8111, 16'h0200, 1'b0, 1'b0);
        step(1'b1, 16'h8222, 16'h0202, 1'b0, 1'b0);
        step(1'b1, 16'h8333, 16'h0204, 1'b1, 1'b1);
        tests_run += 4;
        if (count !== CNT_W'(0)) begin tests_failed++; $display("FAIL flush_full_count: got %0d expected 0", count); end
        if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_full_valid: got %b expected 0", id_valid); end
        if (id_instr !== 16'h0800) begin tests_failed++; $display("FAIL flush_full_nop: got %h expected 0800", id_instr); end
        if (if_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_full_ready: got %b expected 1", if_ready); end
        // Flush concurrent with an enqueue into a non-full queue must also discard it.
        step(1'b1, 16'h8444, 16'h0206, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tests_run += 2;
        if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_enq_dropped_valid: got %b expected 0", id_valid); end
        if (id_instr === 16'h8444 || id_instr === 16'h8333) begin
            tests_failed++;
            $display("FAIL flush_enq_dropped_instr: got %h expected 0800", id_instr);
        end
    endtask

    task automatic test_random();
        logic        v;
        logic        rdy;
        logic        fl;
        logic [15:0] ins;
        logic [15:0] p;
        for (int i = 0; i < 400; i++) begin
            tests_run += 7;
            if (count !== CNT_W'(mq_instr.size())) begin tests_failed++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, count, mq_instr.size()); end
            if (if_ready !== exp_ready()) begin tests_failed++; $display("FAIL rand_if_ready[%0d]: got %b expected %b", i, if_ready, exp_ready()); end
            if (id_valid !== (mq_instr.size() != 0)) begin tests_failed++; $display("FAIL rand_id_valid[%0d]: got %b", i, id_valid); end
            if (halt_seen !== m_halt) begin tests_failed++; $display("FAIL rand_halt_seen[%0d]: got %b expected %b", i, halt_seen, m_halt); end
            if (id_instr !== exp_instr()) begin tests_failed++; $display("FAIL rand_id_instr[%0d]: got %h expected %h", i, id_instr, exp_instr()); end
            if (id_pc !== exp_pc()) begin tests_failed++; $display("FAIL rand_id_pc[%0d]: got %h expected %h", i, id_pc, exp_pc()); end
            if (id_pc_inc !== exp_pc_inc()) begin tests_failed++; $display("FAIL rand_id_pc_inc[%0d]: got %h expected %h", i, id_pc_inc, exp_pc_inc()); end
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            ins = 16'($urandom);
            p   = 16'($urandom) & 16'hFFFE;
            step(v, ins, p, rdy, fl);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 16'h8555, 16'h0300, 1'b0, 1'b0);
        step(1'b1, 16'h0000, 16'h0302, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        tests_run += 7;
        if (if_ready !== 1'b1) begin tests_failed++; $display("FAIL async_rst_if_ready: got %b expected 1", if_ready); end
        if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL async_rst_id_valid: got %b expected 0", id_valid); end
        if (id_instr !== 16'h0800) begin tests_failed++; $display("FAIL async_rst_id_instr: got %h expected 0800", id_instr); end
        if (id_pc !== 16'h0000) begin tests_failed++; $display("FAIL async_rst_id_pc: got %h expected 0000", id_pc); end
        if (id_pc_inc !== 16'h0000) begin tests_failed++; $display("FAIL async_rst_id_pc_inc: got %h expected 0000", id_pc_inc); end
        if (halt_seen !== 1'b0) begin tests_failed++; $display("FAIL async_rst_halt_seen: got %b expected 0", halt_seen); end
        if (count !== CNT_W'(0)) begin tests_failed++; $display("FAIL async_rst_count: got %0d expected 0", count); end
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 16'h8666, 16'h0400, 1'b0, 1'b0);
        tests_run++;
        if (id_instr !== 16'h8666) begin tests_failed++; $display("FAIL post_rst_enqueue: got %h expected 8666", id_instr); end
    endtask

    initial begin
        rst      = 1'b1;
        if_valid = 1'b0;
        if_instr = '0;
        if_pc    = '0;
        id_ready = 1'b0;
        flush    = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        test_reset();
        test_fill_drain();
        test_streaming();
        test_pc_wrap();
        test_halt_flush();
        test_flush_full();
        test_random();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
